fetch_branch_unit: RTL and testbench

//  Parametrised instruction-fetch and branch-resolution front end for the next-generation core.

---
 rtl/core_pkg.sv | 24 ++
 rtl/branch_cond.sv | 24 ++
 rtl/fetch_branch_unit.sv | 108 ++++++++++
 tb/tb_fetch_branch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the fetch/branch front end: branch types, flag bit
// positions and the fetch FSM state encoding.
package core_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BEN  = 3'b010;
    localparam logic [2:0] BR_BVF  = 3'b011;
    localparam logic [2:0] BR_BCS  = 3'b100;
    localparam logic [2:0] BR_J    = 3'b101;
    localparam logic [2:0] BR_JR   = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: says whether a branch/jump of the given type
// would be taken against the supplied {N,V,Z,C} flags.
module branch_cond
    import core_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = flags[FLAG_Z];
            BR_BEN:  taken = flags[FLAG_N] | flags[FLAG_Z];
            BR_BVF:  taken = flags[FLAG_V];
            BR_BCS:  taken = flags[FLAG_C];
            BR_J,
            BR_JR:   taken = 1'b1;
            default: taken = 1'b0;  // none and reserved 111
        endcase
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// Instruction-fetch and branch-resolution front end: owns the PC, the flag
// register and the imem request handshake; redirects on taken branches.
module fetch_branch_unit
    import core_pkg::*;
#(
    parameter int              XLEN            = 32,  // must exceed 28 for the j target
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter bit              CLR_FLAGS_ON_BR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            flag_we,
    input  logic [3:0]      flags_in,
    output logic [3:0]      flags,
    input  logic            br_valid,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] br_pc,
    input  logic [15:0]     br_off,
    input  logic [25:0]     j_target,
    input  logic [XLEN-1:0] jr_addr,
    output logic            redirect
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drop_addr;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] off_ext;
    logic [XLEN-1:0] target;
    logic            cond_taken;
    logic            taken;
    logic            fetch_ack;

    branch_cond u_cond (
        .br_type (br_type),
        .flags   (flags),
        .taken   (cond_taken)
    );

    assign taken     = br_valid & cond_taken;
    assign fetch_ack = (state == ST_FETCH) & imem_ack;
    assign seq_pc    = br_pc + XLEN'(4);
    assign off_ext   = {{(XLEN-18){br_off[15]}}, br_off, 2'b00};

    always_comb begin
        target = seq_pc + off_ext;
        case (br_type)
            BR_J:    target = {seq_pc[XLEN-1:28], j_target, 2'b00};
            BR_JR:   target = {jr_addr[XLEN-1:2], 2'b00};
            default: target = seq_pc + off_ext;
        endcase
    end

    // Outputs and next state; imem_req is forced low while reset is asserted.
    always_comb begin
        state_nxt   = state;
        imem_req    = rst_n & (state != ST_HOLD);
        imem_addr   = (state == ST_DROP) ? drop_addr : pc;
        instr_valid = (state == ST_HOLD);
        case (state)
            ST_FETCH: begin
                if (taken)         state_nxt = imem_ack ? ST_FETCH : ST_DROP;
                else if (imem_ack) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (taken || instr_ready) state_nxt = ST_FETCH;
            end
            ST_DROP: begin
                if (imem_ack) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            flags     <= '0;
            instr     <= '0;
            instr_pc  <= '0;
            redirect  <= 1'b0;
        end else begin
            state    <= state_nxt;
            redirect <= taken;
            if (taken)          pc <= target;
            else if (fetch_ack) pc <= pc + XLEN'(4);
            if (fetch_ack && !taken) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            // Remember the in-flight address so it stays stable until the stale ack.
            if ((state == ST_FETCH) && taken && !imem_ack) drop_addr <= pc;
            if (flag_we)                          flags <= flags_in;
            else if (br_valid && CLR_FLAGS_ON_BR) flags <= '0;
        end
    end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        flag_we = 1'b0;
    logic [3:0]  flags_in = '0;
    logic [3:0]  flags;
    logic        br_valid = 1'b0;
    logic [2:0]  br_type = '0;
    logic [31:0] br_pc = '0;
    logic [15:0] br_off = '0;
    logic [25:0] j_target = '0;
    logic [31:0] jr_addr = '0;
    logic        redirect;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_branch_unit #(.XLEN(32), .RESET_PC(32'h0), .CLR_FLAGS_ON_BR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .flag_we(flag_we), .flags_in(flags_in), .flags(flags),
        .br_valid(br_valid), .br_type(br_type), .br_pc(br_pc), .br_off(br_off),
        .j_target(j_target), .jr_addr(jr_addr), .redirect(redirect)
    );

    // Model: the fetch front end is either waiting on a request (possibly a
    // stale one to be thrown away) or holding one instruction for decode.
    logic [31:0] m_pc, m_instr, m_ipc, m_req_addr;
    logic [3:0]  m_flags;
    bit          m_have, m_discard, m_redir;

    function automatic bit m_cond(input logic [2:0] t, input logic [3:0] f);
        case (t)
            3'd1: return f[1];
            3'd2: return f[3] | f[1];
            3'd3: return f[2];
            3'd4: return f[0];
            3'd5, 3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [2:0] t, input logic [31:0] bpc,
                                             input logic [15:0] boff, input logic [25:0] jt,
                                             input logic [31:0] jra);
        logic [31:0] nxt, off;
        nxt = bpc + 32'd4;
        off = {{16{boff[15]}}, boff};
        if (t == 3'd5) return {nxt[31:28], jt, 2'b00};
        if (t == 3'd6) return jra & 32'hFFFF_FFFC;
        return nxt + off * 32'd4;
    endfunction

    task automatic m_reset();
        m_pc = 32'h0; m_flags = 4'h0; m_have = 0; m_discard = 0; m_redir = 0;
        m_instr = '0; m_ipc = '0; m_req_addr = '0;
    endtask

    task automatic m_step();
        bit tk;
        logic [31:0] tgt;
        tk  = br_valid && m_cond(br_type, m_flags);
        tgt = m_target(br_type, br_pc, br_off, j_target, jr_addr);
        if (!m_have) begin
            if (imem_ack) begin
                if (!m_discard && !tk) begin
                    m_have = 1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                end
                m_discard = 0;
            end else if (tk && !m_discard) begin
                m_discard = 1; m_req_addr = m_pc;
            end
        end else if (tk || instr_ready) begin
            m_have = 0;
        end
        if (tk) m_pc = tgt;
        if (flag_we)       m_flags = flags_in;
        else if (br_valid) m_flags = 4'h0;
        m_redir = tk;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req", imem_req, !m_have);
        if (!m_have) chk("imem_addr", imem_addr, m_discard ? m_req_addr : m_pc);
        chk("instr_valid", instr_valid, m_have);
        if (m_have) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
        chk("flags", flags, m_flags);
        chk("redirect", redirect, m_redir);
    endtask

    // One clock: model follows the DUT edge, compare at the falling edge,
    // then return the pulse-style inputs to idle.
    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare_all();
        imem_ack = 0; instr_ready = 0; flag_we = 0; br_valid = 0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_redirect", redirect, 0);
        rst_n = 1;
        #1 compare_all();

        // Reset release, ack two cycles later
        tick(); tick();
        chk("t1_addr", imem_addr, 32'h0);
        imem_ack = 1; imem_rdata = 32'h8C41_0004;
        tick();
        chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr, 32'h8C41_0004);
        chk("t1_ipc", instr_pc, 32'h0);
        instr_ready = 1;
        tick();
        chk("t1_next_addr", imem_addr, 32'h4);

        // beq taken with Z, request still outstanding: address held until stale ack
        flag_we = 1; flags_in = 4'b0010;
        tick();
        chk("t2_flagsZ", flags, 4'b0010);
        br_valid = 1; br_type = 3'b001; br_pc = 32'h10; br_off = 16'hFFFE;
        tick();
        chk("t2_redirect", redirect, 1);
        chk("t2_flags_clr", flags, 4'h0);
        chk("t4_addr_held0", imem_addr, 32'h4);
        tick();
        chk("t2_pulse_end", redirect, 0);
        tick(); tick();
        chk("t4_addr_held3", imem_addr, 32'h4);
        chk("t4_no_valid", instr_valid, 0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t4_discard", instr_valid, 0);
        chk("t2_new_addr", imem_addr, 32'h0C);

        // bvf uses pre-update flags; flag_we wins over the branch clear
        flag_we = 1; flags_in = 4'b0100;
        tick();
        chk("t3_flagsV", flags, 4'b0100);
        br_valid = 1; br_type = 3'b011; br_pc = 32'h20; br_off = 16'h0001;
        flag_we = 1; flags_in = 4'b0001;
        tick();
        chk("t3_redirect", redirect, 1);
        chk("t3_flags", flags, 4'b0001);
        imem_ack = 1;
        tick();
        chk("t3_addr", imem_addr, 32'h28);

        // j near the top of the address space, then wrap
        br_valid = 1; br_type = 3'b101; br_pc = 32'hF000_0000; j_target = 26'h3FF_FFFF;
        tick();
        chk("t5_redirect", redirect, 1);
        imem_ack = 1;
        tick();
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        chk("t5_ipc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1;
        tick();
        chk("t5_wrap", imem_addr, 32'h0);

        // Asynchronous reset while holding an instruction
        flag_we = 1; flags_in = 4'hF; imem_ack = 1; imem_rdata = 32'hA5A5_A5A5;
        tick();
        chk("t6_hold", instr_valid, 1);
        chk("t6_flags", flags, 4'hF);
        #2 rst_n = 0;
        #1;
        chk("t6_valid", instr_valid, 0);
        chk("t6_flags0", flags, 4'h0);
        chk("t6_req", imem_req, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        #1 compare_all();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 0;
                #1 m_reset();
                @(negedge clk);
                rst_n = 1;
                #1 compare_all();
            end
            imem_ack    = imem_req && ($urandom_range(0, 2) == 0);
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            flag_we     = ($urandom_range(0, 3) == 0);
            flags_in    = 4'($urandom);
            br_valid    = ($urandom_range(0, 3) == 0);
            br_type     = 3'($urandom);
            br_pc       = $urandom & 32'hFFFF_FFFC;
            br_off      = 16'($urandom);
            j_target    = 26'($urandom);
            jr_addr     = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
